// File: rtl/gpr_pkg.sv
// gpr_pkg: shared state encoding, register indices and first-write priority for the GPR writeback sequencer
package gpr_pkg;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_W-1:0] LINK_REG = 5'd31;
    localparam logic [REG_W-1:0] OVF_REG  = 5'd30;
    localparam logic [31:0]      OVF_VAL  = 32'h1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_LINK = 2'd1,
        WR_MAIN = 2'd2,
        WR_OVF  = 2'd3
    } state_t;

    // Writes are issued in the fixed order link, main, overflow.
    function automatic state_t first_state(input logic link, input logic main, input logic ovf);
        return link ? WR_LINK : main ? WR_MAIN : ovf ? WR_OVF : IDLE;
    endfunction
endpackage

// File: rtl/gpr_wb_seq_if.sv
// gpr_wb_seq_if: result-bundle handshake from MEM/WB plus the single register-file write port
//   in_valid/in_ready   bundle handshake
//   in_wen/in_rw/in_data destination write request
//   in_jal/in_link      link write request and address
//   in_over             arithmetic overflow flag
//   RegWr/rw/busW       register-file write port
//   busy                a write is being issued
interface gpr_wb_seq_if;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_wen;
    logic [gpr_pkg::REG_W-1:0]  in_rw;
    logic [31:0]                in_data;
    logic                       in_jal;
    logic [31:0]                in_link;
    logic                       in_over;
    logic                       RegWr;
    logic [gpr_pkg::REG_W-1:0]  rw;
    logic [31:0]                busW;
    logic                       busy;

    modport master (
        output in_valid, in_wen, in_rw, in_data, in_jal, in_link, in_over,
        input  in_ready, RegWr, rw, busW, busy
    );

    modport slave (
        input  in_valid, in_wen, in_rw, in_data, in_jal, in_link, in_over,
        output in_ready, RegWr, rw, busW, busy
    );
endinterface

// File: rtl/gpr_wb_seq.sv
// gpr_wb_seq: expands one retired-instruction result bundle into ordered single-register writes
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   io   slave side of gpr_wb_seq_if (bundle handshake in, register-file write port out)
module gpr_wb_seq #(
    parameter logic [gpr_pkg::REG_W-1:0] LINK_REG = gpr_pkg::LINK_REG,
    parameter logic [gpr_pkg::REG_W-1:0] OVF_REG  = gpr_pkg::OVF_REG,
    parameter logic [31:0]               OVF_VAL  = gpr_pkg::OVF_VAL
) (
    input logic          clk,
    input logic          rst,
    gpr_wb_seq_if.slave  io
);
    import gpr_pkg::*;

    state_t           state;
    state_t           nxt;
    logic             r_main;
    logic             r_ovf;
    logic             ready;
    logic             need_main;
    logic             accept;
    logic [REG_W-1:0] rw_l;
    logic [31:0]      data_l;

    // r_main/r_ovf hold the writes still owed after the one currently on the port,
    // so with none owed the current write is the bundle's last and a new bundle may enter.
    assign ready       = !(r_main || r_ovf);
    assign io.in_ready = ready;
    assign io.busy     = state != IDLE;
    assign need_main   = io.in_wen && !io.in_over && io.in_rw != REG_ZERO;
    assign accept      = io.in_valid && ready;
    assign nxt         = r_main ? WR_MAIN :
                         r_ovf  ? WR_OVF  :
                         accept ? first_state(io.in_jal, need_main, io.in_over) : IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            r_main   <= 1'b0;
            r_ovf    <= 1'b0;
            rw_l     <= '0;
            data_l   <= '0;
            io.RegWr <= 1'b0;
            io.rw    <= '0;
            io.busW  <= '0;
        end else begin
            state    <= nxt;
            io.RegWr <= nxt != IDLE;
            // Only a link-first bundle can owe further writes; main and overflow are exclusive.
            if (accept) begin
                r_main <= io.in_jal && need_main;
                r_ovf  <= io.in_jal && io.in_over;
                rw_l   <= io.in_rw;
                data_l <= io.in_data;
            end else begin
                r_main <= 1'b0;
                r_ovf  <= 1'b0;
            end
            case (nxt)
                WR_LINK: begin
                    io.rw   <= LINK_REG;
                    io.busW <= io.in_link;
                end
                WR_MAIN: begin
                    io.rw   <= r_main ? rw_l : io.in_rw;
                    io.busW <= r_main ? data_l : io.in_data;
                end
                WR_OVF: begin
                    io.rw   <= OVF_REG;
                    io.busW <= OVF_VAL;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gpr_wb_seq.sv
// tb_gpr_wb_seq: self-checking bench for gpr_wb_seq against a queue-of-writes reference model
module tb_gpr_wb_seq;
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    wr_t         q[$];
    logic        e_wen = 1'b0;
    logic [4:0]  e_rw = '0;
    logic [31:0] e_bus = '0;
    logic        obs_ready;
    logic        exp_ready;
    logic [39:0] obs;
    logic [39:0] exp;

    gpr_wb_seq_if bus();

    gpr_wb_seq dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus, advance the model, and capture observed/expected
    // {in_ready, RegWr, rw, busW, busy}. Model: every accepted bundle appends its writes
    // (link, destination, overflow) to a queue; one write leaves the queue per cycle.
    task automatic drive(input logic v, input logic w, input logic [4:0] r, input logic [31:0] d,
                         input logic j, input logic [31:0] l, input logic o);
        wr_t  x;
        logic acc;
        bus.in_valid = v;
        bus.in_wen   = w;
        bus.in_rw    = r;
        bus.in_data  = d;
        bus.in_jal   = j;
        bus.in_link  = l;
        bus.in_over  = o;
        #1;
        obs_ready = bus.in_ready;
        exp_ready = q.size() == 0;
        acc = v && exp_ready;
        @(posedge clk);
        if (acc) begin
            if (j) q.push_back('{5'd31, l});
            if (w && !o && r != 5'd0) q.push_back('{r, d});
            if (o) q.push_back('{5'd30, 32'h1});
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            e_wen = 1'b1;
            e_rw  = x.r;
            e_bus = x.d;
        end else begin
            e_wen = 1'b0;
        end
        #1;
        obs = {obs_ready, bus.RegWr, bus.rw, bus.busW, bus.busy};
        exp = {exp_ready, e_wen, e_rw, e_bus, e_wen};
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_wen = 1'b0;
        bus.in_rw = '0;
        bus.in_data = '0;
        bus.in_jal = 1'b0;
        bus.in_link = '0;
        bus.in_over = 1'b0;
        #3;
        obs = {bus.in_ready, bus.RegWr, bus.rw, bus.busW, bus.busy};
        checks++;
        if (obs !== {1'b1, 39'h0}) $display("FAIL reset: got %h want %h", obs, {1'b1, 39'h0});
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.RegWr, bus.rw, bus.busW} !== {1'b1, 5'd8, 32'hDEADBEEF})
            $display("FAIL add_write: got %h want %h", {bus.RegWr, bus.rw, bus.busW}, {1'b1, 5'd8, 32'hDEADBEEF});
        else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== exp) $display("FAIL add c%0d: got %h want %h", i, obs, exp);
            else passed++;
            idle();
        end
    endtask

    task automatic test_jal();
        drive(1'b1, 1'b0, 5'd4, 32'h0, 1'b1, 32'h00400010, 1'b0);
        checks++;
        if ({bus.RegWr, bus.rw, bus.busW} !== {1'b1, 5'd31, 32'h00400010})
            $display("FAIL jal_write: got %h want %h", {bus.RegWr, bus.rw, bus.busW}, {1'b1, 5'd31, 32'h00400010});
        else passed++;
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if (obs !== exp) $display("FAIL jal c%0d: got %h want %h", i, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 5'd31, 32'h5, 1'b1, 32'h00400020, 1'b0);
        checks++;
        if (obs !== exp) $display("FAIL collision c0: got %h want %h", obs, exp);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd12, 32'hC0 + i, 1'b0, 32'h0, 1'b0);
            checks++;
            if (obs !== exp) $display("FAIL collision c%0d: got %h want %h", i, obs, exp);
            else passed++;
        end
        idle();
    endtask

    task automatic test_overflow();
        int hit9 = 0;
        drive(1'b1, 1'b1, 5'd9, 32'h1234, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({bus.RegWr, bus.rw, bus.busW} !== {1'b1, 5'd30, 32'h1})
            $display("FAIL ovf_write: got %h want %h", {bus.RegWr, bus.rw, bus.busW}, {1'b1, 5'd30, 32'h1});
        else passed++;
        drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 32'h00400040, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp) $display("FAIL ovf c%0d: got %h want %h", i, obs, exp);
            else passed++;
            if (bus.RegWr && bus.rw == 5'd9) hit9++;
            idle();
        end
        checks++;
        if (hit9 !== 0) $display("FAIL ovf_no_rw9: got %0d want 0", hit9);
        else passed++;
    endtask

    task automatic test_zero();
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF0000, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({bus.RegWr, bus.busy} !== 2'b00) $display("FAIL zero_idx: got %b want 00", {bus.RegWr, bus.busy});
        else passed++;
        checks++;
        if (obs !== exp) $display("FAIL zero c0: got %h want %h", obs, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int wc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'(i + 1), 32'hA000 + i, 1'b0, 32'h0, 1'b0);
            wc += int'(bus.RegWr);
            checks++;
            if (obs !== exp) $display("FAIL b2b c%0d: got %h want %h", i, obs, exp);
            else passed++;
        end
        checks++;
        if (wc !== 4) $display("FAIL b2b_count: got %0d want 4", wc);
        else passed++;
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 5'd7, 32'h77, 1'b1, 32'h00400080, 1'b1);
        checks++;
        if (obs !== exp) $display("FAIL rstmid link: got %h want %h", obs, exp);
        else passed++;
        rst = 1'b0;
        #1;
        obs = {bus.in_ready, bus.RegWr, bus.rw, bus.busW, bus.busy};
        checks++;
        if (obs !== {1'b1, 39'h0}) $display("FAIL rstmid async: got %h want %h", obs, {1'b1, 39'h0});
        else passed++;
        q.delete();
        e_wen = 1'b0;
        e_rw  = '0;
        e_bus = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (obs !== exp) $display("FAIL rstmid c%0d: got %h want %h", i, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [4:0] r;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: r = 5'd0;
                1: r = 5'd31;
                2: r = 5'd30;
                default: r = 5'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r, $urandom,
                  $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) == 0);
            checks++;
            if (obs !== exp) $display("FAIL rand c%0d: got %h want %h", i, obs, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_jal();
        test_collision();
        test_overflow();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
